// File: rtl/ha_array_final_adder_if.sv
// rtl/ha_array_final_adder_if.sv - row input and product output handshake bundle for ha_array_final_adder
interface ha_array_final_adder_if #(
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       ha_array_0_t;
    logic [6:0]       ha_array_0_b;
    logic [8:0]       ha_array_1_t;
    logic [6:0]       ha_array_1_b;
    logic [8:0]       ha_array_2_t;
    logic [6:0]       ha_array_2_b;
    logic [8:0]       ha_array_3_t;
    logic [6:0]       ha_array_3_b;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] product;
    logic             sat;
    logic [CNT_W-1:0] sat_count;

    modport master (
        output in_valid,
        output ha_array_0_t, output ha_array_0_b,
        output ha_array_1_t, output ha_array_1_b,
        output ha_array_2_t, output ha_array_2_b,
        output ha_array_3_t, output ha_array_3_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  sat,
        input  sat_count
    );

    modport slave (
        input  in_valid,
        input  ha_array_0_t, input ha_array_0_b,
        input  ha_array_1_t, input ha_array_1_b,
        input  ha_array_2_t, input ha_array_2_b,
        input  ha_array_3_t, input ha_array_3_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output sat,
        output sat_count
    );
endinterface

// File: rtl/ha_array_final_adder.sv
// rtl/ha_array_final_adder.sv - three-stage reduction of four ha_array rows into the 16-bit product
module ha_array_final_adder #(
    parameter int OUT_W    = 16,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ha_array_final_adder_if.slave   bus
);

    // Row views: index j is row j; b bits sit two places above the t bits.
    logic [3:0][8:0] t_in;
    logic [3:0][6:0] b_in;

    assign t_in = {bus.ha_array_3_t, bus.ha_array_2_t, bus.ha_array_1_t, bus.ha_array_0_t};
    assign b_in = {bus.ha_array_3_b, bus.ha_array_2_b, bus.ha_array_1_b, bus.ha_array_0_b};

    // Pipeline state: valid bits are reset, stage 1-2 data is not.
    logic            v1_q, v2_q, v3_q;
    logic            v1_d, v2_d, v3_d;
    logic [3:0][9:0] r_d, r_q;
    logic [12:0]     s01_d, s23_d, s01_q, s23_q;
    logic [OUT_W:0]  p_d;
    logic [OUT_W-1:0] product_d, product_q;
    logic            sat_d, sat_q;
    logic [CNT_W-1:0] sat_count_d, sat_count_q;

    logic ld1, ld2, ld3, out_fire;

    // A stage loads when it is empty or its successor takes its beat this cycle.
    assign out_fire = v3_q && bus.out_ready;
    assign ld3      = v2_q && (!v3_q || bus.out_ready);
    assign ld2      = v1_q && (!v2_q || ld3);
    assign ld1      = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !v1_q || ld2;
    assign bus.out_valid = v3_q;
    assign bus.product   = product_q;
    assign bus.sat       = sat_q;
    assign bus.sat_count = sat_count_q;

    // Stage 1 row fold: R_j = t_j + 4*b_j, at most 1019.
    always_comb begin
        r_d = '0;
        for (int j = 0; j < 4; j++) begin
            r_d[j] = {1'b0, t_in[j]} + {1'b0, b_in[j], 2'b00};
        end
    end

    // Stage 2/3 pair sums, then final weighted sum with optional clamp.
    always_comb begin
        s01_d     = {3'b000, r_q[0]} + {1'b0, r_q[1], 2'b00};
        s23_d     = {3'b000, r_q[2]} + {1'b0, r_q[3], 2'b00};
        p_d       = {4'b0000, s01_q} + {s23_q, 4'b0000};
        sat_d     = p_d[OUT_W];
        product_d = (SATURATE && sat_d) ? {OUT_W{1'b1}} : p_d[OUT_W-1:0];
    end

    // Next-state for valid bits and the non-wrapping saturation counter.
    always_comb begin
        v1_d        = ld1 ? 1'b1 : (ld2 ? 1'b0 : v1_q);
        v2_d        = ld2 ? 1'b1 : (ld3 ? 1'b0 : v2_q);
        v3_d        = ld3 ? 1'b1 : (bus.out_ready ? 1'b0 : v3_q);
        sat_count_d = sat_count_q;
        if (out_fire && sat_q && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    // Control and output registers; reset drops any in-flight beats at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            product_q   <= '0;
            sat_q       <= 1'b0;
            sat_count_q <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            sat_count_q <= sat_count_d;
            if (ld3) begin
                product_q <= product_d;
                sat_q     <= sat_d;
            end
        end
    end

    // Stage 1-2 data only captures on a load, so idle-cycle row garbage never enters.
    always_ff @(posedge clk) begin
        if (ld1) begin
            r_q <= r_d;
        end
        if (ld2) begin
            s01_q <= s01_d;
            s23_q <= s23_d;
        end
    end

endmodule

// File: tb/tb_ha_array_final_adder.sv
// tb/tb_ha_array_final_adder.sv - self-checking bench for ha_array_final_adder
module tb_ha_array_final_adder;

    localparam int OUT_W = 16;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ha_array_final_adder_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus_s ();
    ha_array_final_adder_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus_t ();

    // The truncating instance sees exactly the same stimulus.
    assign bus_t.in_valid     = bus_s.in_valid;
    assign bus_t.out_ready    = bus_s.out_ready;
    assign bus_t.ha_array_0_t = bus_s.ha_array_0_t;
    assign bus_t.ha_array_0_b = bus_s.ha_array_0_b;
    assign bus_t.ha_array_1_t = bus_s.ha_array_1_t;
    assign bus_t.ha_array_1_b = bus_s.ha_array_1_b;
    assign bus_t.ha_array_2_t = bus_s.ha_array_2_t;
    assign bus_t.ha_array_2_b = bus_s.ha_array_2_b;
    assign bus_t.ha_array_3_t = bus_s.ha_array_3_t;
    assign bus_t.ha_array_3_b = bus_s.ha_array_3_b;

    ha_array_final_adder #(.OUT_W(OUT_W), .SATURATE(1'b1), .CNT_W(CNT_W)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    ha_array_final_adder #(.OUT_W(OUT_W), .SATURATE(1'b0), .CNT_W(CNT_W)) u_trn (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_t)
    );

    typedef struct {
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        logic [15:0]     exp_s;
        logic [15:0]     exp_t;
        logic            exp_sat;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;
    int n_out   = 0;
    int exp_cnt = 0;
    bit mon_en  = 1'b0;
    bit last_acc;
    logic [16:0]     exp_q[$];
    logic [3:0][8:0] cur_t;
    logic [3:0][6:0] cur_b;
    vec_t            vt[8];

    // Product as the weighted sum of rows: row j weighs 4^j, b bits weigh 4x their t bits.
    function automatic logic [16:0] ref_p(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
        int acc = 0;
        for (int j = 0; j < 4; j++) begin
            acc += (int'(t[j]) + 4 * int'(b[j])) * (4 ** j);
        end
        return acc[16:0];
    endfunction

    function automatic vec_t mk(input logic [3:0][8:0] t, input logic [3:0][6:0] b,
                                input logic [15:0] es, input logic [15:0] et, input logic s);
        vec_t v;
        v.t = t; v.b = b; v.exp_s = es; v.exp_t = et; v.exp_sat = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_rows(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
        cur_t = t;
        cur_b = b;
        bus_s.ha_array_0_t = t[0]; bus_s.ha_array_0_b = b[0];
        bus_s.ha_array_1_t = t[1]; bus_s.ha_array_1_b = b[1];
        bus_s.ha_array_2_t = t[2]; bus_s.ha_array_2_b = b[2];
        bus_s.ha_array_3_t = t[3]; bus_s.ha_array_3_b = b[3];
    endtask

    task automatic set_t0(input logic [8:0] v);
        set_rows({9'h0, 9'h0, 9'h0, v}, '0);
    endtask

    task automatic rand_rows();
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        for (int j = 0; j < 4; j++) begin
            t[j] = 9'($urandom);
            b[j] = 7'($urandom);
        end
        set_rows(t, b);
    endtask

    // One clock: observe handshakes at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [16:0] p;
        @(negedge clk);
        last_acc = bus_s.in_valid && bus_s.in_ready;
        if (mon_en) begin
            chk("valid_agree", bus_t.out_valid, bus_s.out_valid);
            if (last_acc) exp_q.push_back(ref_p(cur_t, cur_b));
            if (bus_s.out_valid && bus_s.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL output_without_input: got product 0x%0h expected no output", bus_s.product);
                end else begin
                    p = exp_q.pop_front();
                    chk("mon_product_sat", bus_s.product, p[16] ? 16'hFFFF : p[15:0]);
                    chk("mon_product_trunc", bus_t.product, p[15:0]);
                    chk("mon_sat", bus_s.sat, p[16]);
                    chk("mon_sat_trunc", bus_t.sat, p[16]);
                    if (p[16] && exp_cnt < 65535) exp_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input vec_t v, input string tag);
        int w;
        set_rows(v.t, v.b);
        bus_s.in_valid  = 1'b1;
        bus_s.out_ready = 1'b1;
        w = 0;
        do begin tick(); w++; end while (!last_acc && w < 10);
        chk({tag, "_accepted"}, last_acc, 1);
        bus_s.in_valid = 1'b0;
        w = 0;
        while (!bus_s.out_valid && w < 10) begin tick(); w++; end
        chk({tag, "_out_valid"}, bus_s.out_valid, 1);
        chk({tag, "_product_sat"}, bus_s.product, v.exp_s);
        chk({tag, "_product_trunc"}, bus_t.product, v.exp_t);
        chk({tag, "_sat"}, bus_s.sat, v.exp_sat);
        tick();
    endtask

    initial begin
        int lat, k, n0, acc, hold;

        vt[0] = mk({9'h0, 9'h0, 9'h0, 9'h001}, '0, 16'h0001, 16'h0001, 1'b0);
        vt[1] = mk({9'h100, 9'h0, 9'h0, 9'h0}, '0, 16'h4000, 16'h4000, 1'b0);
        vt[2] = mk('0, {7'h40, 7'h0, 7'h0, 7'h0}, 16'h4000, 16'h4000, 1'b0);
        vt[3] = mk({4{9'h1FF}}, {4{7'h7F}}, 16'hFFFF, 16'h5257, 1'b1);
        vt[4] = mk('0, {7'h0, 7'h0, 7'h0, 7'h01}, 16'h0004, 16'h0004, 1'b0);
        vt[5] = mk({9'h0, 9'h001, 9'h0, 9'h0}, '0, 16'h0010, 16'h0010, 1'b0);
        vt[6] = mk({4{9'h1FF}}, '0, 16'hA9AB, 16'hA9AB, 1'b0);
        vt[7] = mk('0, {4{7'h7F}}, 16'hA8AC, 16'hA8AC, 1'b0);

        bus_s.in_valid  = 1'b0;
        bus_s.out_ready = 1'b1;
        set_rows('0, '0);

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", bus_s.out_valid, 0);
        chk("rst_product", bus_s.product, 0);
        chk("rst_sat", bus_s.sat, 0);
        chk("rst_sat_count", bus_s.sat_count, 0);
        chk("rst_out_valid_trunc", bus_t.out_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", bus_s.in_ready, 1);
        mon_en = 1'b1;

        // Latency of a lone beat
        set_t0(9'h001);
        bus_s.in_valid = 1'b1;
        tick();
        chk("latency_accept", last_acc, 1);
        bus_s.in_valid = 1'b0;
        lat = 1;
        while (!bus_s.out_valid && lat < 10) begin tick(); lat++; end
        chk("latency_cycles", lat, 3);
        chk("latency_product", bus_s.product, 16'h0001);
        chk("latency_sat", bus_s.sat, 0);
        tick();

        // Vector table
        for (int i = 0; i < 8; i++) send_one(vt[i], $sformatf("vec%0d", i));
        chk("sat_count_after_table", bus_s.sat_count, exp_cnt);
        chk("sat_count_after_table_trunc", bus_t.sat_count, exp_cnt);
        chk("sat_count_is_one", exp_cnt, 1);

        // Backpressure: fill, hold, release
        n0 = n_out;
        bus_s.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            set_t0(9'(k + 1));
            bus_s.in_valid = 1'b1;
            tick();
            if (last_acc) k++;
        end
        chk("stall_accepts", k, 3);
        chk("stall_in_ready", bus_s.in_ready, 0);
        chk("stall_out_valid", bus_s.out_valid, 1);
        hold = int'(bus_s.product);
        chk("stall_head", bus_s.product, 16'h0001);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_hold", bus_s.product, hold);
            chk("stall_hold_valid", bus_s.out_valid, 1);
        end
        bus_s.out_ready = 1'b1;
        for (int c = 0; c < 10 && k < 5; c++) begin
            set_t0(9'(k + 1));
            tick();
            if (last_acc) k++;
        end
        chk("stall_all_accepted", k, 5);
        bus_s.in_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("stall_outputs", n_out - n0, 5);
        chk("stall_queue_empty", exp_q.size(), 0);

        // Continuous random stream
        n0 = n_out;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            rand_rows();
            bus_s.in_valid = 1'b1;
            tick();
            if (last_acc) acc++;
        end
        chk("stream_accepts", acc, 20);
        chk("stream_outputs_during", n_out - n0, 17);
        bus_s.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin rand_rows(); tick(); end
        chk("stream_outputs_total", n_out - n0, 20);
        chk("stream_queue_empty", exp_q.size(), 0);
        chk("stream_sat_count", bus_s.sat_count, exp_cnt);

        // Reset with beats in flight
        bus_s.out_ready = 1'b0;
        set_t0(9'h007);
        bus_s.in_valid = 1'b1;
        tick();
        set_t0(9'h008);
        tick();
        bus_s.in_valid = 1'b0;
        tick();
        chk("pre_reset_out_valid", bus_s.out_valid, 1);
        chk("pre_reset_sat_count", bus_s.sat_count, exp_cnt);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus_s.out_valid, 0);
        chk("async_rst_sat_count", bus_s.sat_count, 0);
        chk("async_rst_product", bus_s.product, 0);
        chk("async_rst_out_valid_trunc", bus_t.out_valid, 0);
        exp_q.delete();
        exp_cnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
        bus_s.out_ready = 1'b1;
        n0 = n_out;
        tick();
        chk("post_reset_in_ready", bus_s.in_ready, 1);
        for (int c = 0; c < 4; c++) tick();
        chk("post_reset_no_stale", n_out - n0, 0);
        send_one(mk({9'h0, 9'h0, 9'h0, 9'h009}, '0, 16'h0009, 16'h0009, 1'b0), "post_reset");
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_sat_count", bus_s.sat_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ha_array_final_adder.md
Name: ha_array_final_adder

Overview:
- Downstream consumer of the unsigned 8x8 approximate half-adder-array stage.
- Takes the four ha_array rows (each a 9-bit t vector and a 7-bit b vector) and reduces them into the 16-bit product.
- Three-stage pipeline with a valid/ready handshake on both sides.
- Optional output saturation, plus a saturation event counter used for error characterisation runs.

Parameters:
- OUT_W, 16, product width; fixed at 16 for 8x8 operands.
- SATURATE, 1, 1 = clamp overflow to all-ones; 0 = truncate to OUT_W bits.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous assert, active-low, synchronous deassert at the source.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage 1 can accept a beat.
- ha_array_0_t  in  9  row 0 sum bits; bit k has weight 2^k.
- ha_array_0_b  in  7  row 0 carry bits; bit k has weight 2^(k+2).
- ha_array_1_t / ha_array_1_b  in  9/7  row 1; same layout as row 0.
- ha_array_2_t / ha_array_2_b  in  9/7  row 2; same layout as row 0.
- ha_array_3_t / ha_array_3_b  in  9/7  row 3; same layout as row 0.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts the product.
- product  out  OUT_W  reduced product.
- sat  out  1  this product overflowed OUT_W bits.
- sat_count  out  CNT_W  number of saturated products accepted downstream.

Behaviour:
- Arithmetic, stage 1:
  - R_j = t_j + (b_j << 2) for j = 0..3, 10 bits each (max 511 + 508 = 1019).
  - The b vectors carry no implicit bit 0/1.
- Arithmetic, stage 2:
  - S01 = R_0 + (R_1 << 2)
  - S23 = R_2 + (R_3 << 2)
  - Both 13 bits.
- Arithmetic, stage 3:
  - P = S01 + (S23 << 4), 17 bits (max 86615).
  - sat = P[16].
  - With SATURATE=1: product = sat ? all-ones : P[15:0].
  - With SATURATE=0: product = P[15:0]; sat is still reported.
- Latency: 3 cycles from input handshake to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - A transfer occurs when valid && ready at a rising clk edge.
  - in_ready and out_valid are registered-path outputs. in_ready may depend combinationally on out_ready (ripple-ready).
  - Stage k loads when it is empty or stage k+1 loads in the same cycle.
  - Stage 3 drains when out_ready=1.
  - in_ready = !v1 || (stage 2 loads this cycle).
- Stalls:
  - While out_valid=1 && out_ready=0, product and sat hold stable.
  - Upstream stages fill; maximum occupancy is 3 beats.
  - No beat is dropped or duplicated.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts a new beat and emits the oldest in the same cycle.
- sat_count:
  - Increments by 1 on each output transfer with sat=1.
  - Saturates at all-ones and does not wrap.
- Reset:
  - rst_n low clears all stage valid bits, product=0, sat=0, sat_count=0, out_valid=0.
  - in_ready=1 from the first cycle after deassertion.
  - Assertion mid-operation discards in-flight beats immediately (asynchronous).
- Data registers in stages 1–2 need no reset. Only valid bits and the outputs are reset.
- X on row inputs while in_valid=0 must not propagate to outputs.

Test Plan:
- Reset, then a beat with only ha_array_0_t=9'h001 -> product=16'h0001, sat=0, out_valid exactly 3 cycles after accept.
- Single beat with only ha_array_3_t[8]=1, then a single beat with only ha_array_3_b[6]=1 -> product=16'h4000 for each.
- All t=9'h1FF, all b=7'h7F -> P=86615, product=16'hFFFF, sat=1, sat_count=1 after transfer. Repeat with SATURATE=0 -> product=16'h5257, sat=1.
- Stream 5 beats (products 1, 2, 3, 4, 5 via ha_array_0_t) with out_ready=0 -> in_ready drops after 3 accepts. Release out_ready -> outputs 1..5 in order with no loss, and product holds stable while stalled.
- Continuous in_valid=1, out_ready=1 for 20 beats with random rows -> one output per cycle, each matching the reference sum formula.
- Assert rst_n low with 2 beats in flight -> out_valid=0 and sat_count=0 immediately. After release, a new beat gives the correct product with no stale output.
